bit_field_packer: RTL and testbench
===================================

Name: bit_field_packer

Overview:
- Streaming bit packer.
- Accepts variable-length bit fields of 0..IN_W bits per beat and concatenates them LSB-first into OUT_W-bit output words.
- Generalises the fixed byte-slice moves to runtime-variable offsets and lengths, with valid/ready on both sides and a last/flush path.
- Sits between field-producing encoders and word-wide buffers/buses.

Parameters:
- OUT_W, 32: output word width in bits; must be >= IN_W.
- IN_W, 16: maximum field width in bits; must be >= 1.
- LEN_W, $clog2(IN_W+1): width of in_len_i (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input field valid
- in_ready_o  out  1  input field accepted when in_valid_i & in_ready_o
- in_data_i  in  IN_W  field bits, LSB-aligned
- in_len_i  in  LEN_W  field length in bits; 0 allowed; values > IN_W clamp to IN_W
- in_last_i  in  1  final field of packet; triggers flush
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  output word taken when out_valid_o & out_ready_i
- out_data_o  out  OUT_W  packed word
- out_bits_o  out  $clog2(OUT_W+1)  number of meaningful bits in out_data_o
- out_last_o  out  1  final word of packet

Behaviour:
- State: buffer buf[OUT_W+IN_W-1:0], fill counter fill (0..OUT_W+IN_W-1), mode FILL/DRAIN.
- Reset (async, rst_ni=0): buf=0, fill=0, mode=FILL. Outputs during and after reset: out_valid_o=0, out_data_o=0, out_bits_o=0, out_last_o=0, in_ready_o=1.
- Field masking: only in_data_i[len-1:0] is used; higher bits are ignored. len=0 inserts nothing.
- Input accept: masked field is written at buf[fill +: len], and fill increases by len.
- Outputs are combinational from registers:
  - out_data_o = buf[OUT_W-1:0]
  - out_valid_o = (fill >= OUT_W) | (mode==DRAIN)
  - out_last_o = (mode==DRAIN) & (fill <= OUT_W)
  - out_bits_o = min(fill, OUT_W)
- Output fire: buf shifts right by OUT_W with zero fill, and fill decreases by OUT_W. If out_last_o was 1, fill becomes 0 and mode returns to FILL.
- in_ready_o = (mode==FILL) & ((fill < OUT_W) | (out_valid_o & out_ready_i)). This creates a combinational path from out_ready_i to in_ready_o, which is permitted.
- Simultaneous input and output fire: apply the shift first, then insert at the post-shift fill. Full-rate throughput is one field per cycle.
- Accepting in_last_i=1 sets mode=DRAIN; no input is accepted until the final word fires.
- Flush with fill=0 (e.g. a last field with len=0 on an empty buffer): emit one word with data 0, out_bits_o=0, out_last_o=1.
- Bits of out_data_o above out_bits_o are always 0.
- Output stability: while out_valid_o & !out_ready_i, out_data_o, out_bits_o and out_last_o hold stable.
- Wrap-around: a field straddling the word boundary has its low part in word N and its high part at bit 0 of word N+1.
- Reset mid-packet (including during DRAIN): buffered bits are discarded and nothing is emitted.

Test Plan (OUT_W=32, IN_W=16):
1. Exact-fill word:
   - Stimulus: fields (0xABC,12), (0x5,4), (0xFFFF,16), last=0.
   - Response: one word 0xFFFF5ABC, out_bits_o=32, out_last_o=0; fill returns to 0.
2. Boundary straddle with flush:
   - Stimulus: (0x111,12), (0x222,12), (0x333,12, last=1).
   - Response: word 0x33222111 (bits=32, last=0), then 0x00000003 (bits=4, last=1); in_ready_o=0 until the second word fires.
3. Masking and clamping:
   - Stimulus: (0xFFFF,4) then (0xFFFF,len=31→16) with last=1.
   - Response: 0x000FFFFF, bits=20, last=1.
4. Backpressure:
   - Stimulus: reach fill>=32, hold out_ready_i=0 for 5 cycles.
   - Response: out_data_o stable and in_ready_o=0 throughout; after ready, back-to-back fields accepted one per cycle with no bubble.
5. Empty flush:
   - Stimulus: on an empty buffer, (0x0,0,last=1).
   - Response: single word data 0, bits=0, last=1; then mode FILL and in_ready_o=1.
6. Reset mid-drain:
   - Stimulus: assert rst_ni=0 while out_valid_o=1 in DRAIN.
   - Response: out_valid_o drops immediately (async); after release, all outputs are 0 and the next packet packs from bit 0.

Source files
------------

// File: rtl/bit_field_packer.sv
// Streaming bit packer: concatenates 0..IN_W-bit fields LSB-first into OUT_W-bit
// words, with valid/ready on both sides and a last-field flush.
module bit_field_packer #(
  parameter int OUT_W = 32,
  parameter int IN_W  = 16,
  parameter int LEN_W = $clog2(IN_W + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IN_W-1:0]            in_data_i,
  input  logic [LEN_W-1:0]           in_len_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_W-1:0]           out_data_o,
  output logic [$clog2(OUT_W+1)-1:0] out_bits_o,
  output logic                       out_last_o
);

  localparam int BUF_W  = OUT_W + IN_W;
  localparam int FILL_W = $clog2(BUF_W);
  localparam int BITS_W = $clog2(OUT_W + 1);

  typedef enum logic {FILL, DRAIN} mode_e;

  mode_e             mode_q, mode_d;
  logic [BUF_W-1:0]  buf_q, buf_d, buf_s;
  logic [FILL_W-1:0] fill_q, fill_d, fill_s;

  logic [LEN_W-1:0]  len_c;
  logic [IN_W-1:0]   field_c;
  logic              full_c;
  logic              out_fire_c;
  logic              in_fire_c;

  // Clamp oversize lengths, then drop every bit at or above the field length
  always_comb begin
    len_c   = (in_len_i > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_len_i;
    field_c = in_data_i & ~({IN_W{1'b1}} << len_c);
  end

  assign full_c      = (fill_q >= FILL_W'(OUT_W));
  assign out_valid_o = full_c | (mode_q == DRAIN);
  assign out_last_o  = (mode_q == DRAIN) & (fill_q <= FILL_W'(OUT_W));
  assign out_data_o  = buf_q[OUT_W-1:0];
  assign out_bits_o  = full_c ? BITS_W'(OUT_W) : BITS_W'(fill_q);
  assign out_fire_c  = out_valid_o & out_ready_i;
  assign in_ready_o  = (mode_q == FILL) & (~full_c | out_fire_c);
  assign in_fire_c   = in_valid_i & in_ready_o;

  // Output shift happens first so a same-cycle field lands at the post-shift fill
  always_comb begin
    buf_s  = buf_q;
    fill_s = fill_q;
    mode_d = mode_q;
    if (out_fire_c) begin
      buf_s = buf_q >> OUT_W;
      if (out_last_o) begin
        fill_s = '0;
        mode_d = FILL;
      end else begin
        fill_s = fill_q - FILL_W'(OUT_W);
      end
    end
    buf_d  = buf_s;
    fill_d = fill_s;
    if (in_fire_c) begin
      buf_d  = buf_s | (BUF_W'(field_c) << fill_s);
      fill_d = fill_s + FILL_W'(len_c);
      if (in_last_i) mode_d = DRAIN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      fill_q <= '0;
      mode_q <= FILL;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: tb/tb_bit_field_packer.sv
// Scoreboard bench for bit_field_packer (OUT_W=32, IN_W=16).
module tb_bit_field_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic [4:0]  in_len_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [5:0]  out_bits_o;
  logic        out_last_o;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  bits;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [63:0] model_buf;
  int          model_fill;

  bit_field_packer #(.OUT_W(32), .IN_W(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_len_i   (in_len_i),
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_bits_o (out_bits_o),
    .out_last_o (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Output monitor: every word that fires on the coming edge is checked against the queue head
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word data=%h bits=%0d last=%0b", out_data_o, out_bits_o, out_last_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({out_data_o, out_bits_o, out_last_o} !== {e.data, e.bits, e.last}) begin
          failures++;
          $display("FAIL word got data=%h bits=%0d last=%0b want data=%h bits=%0d last=%0b",
                   out_data_o, out_bits_o, out_last_o, e.data, e.bits, e.last);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input int bits, input logic last);
    exp_t e;
    e.data = d;
    e.bits = 6'(bits);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] d, input int len, input logic last, output int waits);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_len_i   = 5'(len);
    in_last_i  = last;
    waits      = 0;
    @(negedge clk_i);
    while (!in_ready_o && waits < 200) begin
      waits++;
      @(posedge clk_i); #1;
      if (waits >= 2) out_ready_i = 1'b1;
      @(negedge clk_i);
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b want 1", in_ready_o);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    out_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  // Bit-stream reference model used for the randomized packet
  task automatic model_field(input logic [15:0] d, input int len, input logic last);
    int          eff;
    logic [31:0] m;
    bit          done;
    eff  = (len > 16) ? 16 : len;
    m    = 32'(d) & ((32'h1 << eff) - 32'h1);
    model_buf  = model_buf | (64'(m) << model_fill);
    model_fill = model_fill + eff;
    done = 1'b0;
    while (model_fill >= 32 && !done) begin
      if (last && model_fill == 32) begin
        push_exp(model_buf[31:0], 32, 1'b1);
        done = 1'b1;
        model_fill = 0;
        model_buf = '0;
      end else begin
        push_exp(model_buf[31:0], 32, 1'b0);
        model_buf  = model_buf >> 32;
        model_fill = model_fill - 32;
      end
    end
    if (last && !done) begin
      push_exp(model_buf[31:0], model_fill, 1'b1);
      model_fill = 0;
      model_buf  = '0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_len_i = '0;
    in_last_i = 1'b0; out_ready_i = 1'b1;
    #2;
    checks++;
    if ({out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o} !== {1'b0, 32'h0, 6'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_during v=%0b d=%h b=%0d l=%0b r=%0b want 0 0 0 0 1",
               out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o} !== {1'b0, 32'h0, 6'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_after v=%0b d=%h b=%0d l=%0b r=%0b want 0 0 0 0 1",
               out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_exact_fill();
    int w;
    push_exp(32'hFFFF5ABC, 32, 1'b0);
    send(16'h0ABC, 12, 1'b0, w);
    send(16'h0005, 4, 1'b0, w);
    send(16'hFFFF, 16, 1'b0, w);
    wait_empty();
    checks++;
    if (out_valid_o !== 1'b0 || out_bits_o !== 6'd0) begin
      failures++;
      $display("FAIL exact_fill_empty valid=%0b bits=%0d want 0 0", out_valid_o, out_bits_o);
    end
  endtask

  task automatic test_straddle_flush();
    int w;
    push_exp(32'h33222111, 32, 1'b0);
    push_exp(32'h00000003, 4, 1'b1);
    send(16'h0111, 12, 1'b0, w);
    send(16'h0222, 12, 1'b0, w);
    send(16'h0333, 12, 1'b1, w);
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL straddle_ready_drain1 got=%0b want 0", in_ready_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (in_ready_o !== 1'b0 || out_last_o !== 1'b1) begin
      failures++;
      $display("FAIL straddle_ready_drain2 ready=%0b last=%0b want 0 1", in_ready_o, out_last_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL straddle_after ready=%0b valid=%0b want 1 0", in_ready_o, out_valid_o);
    end
    wait_empty();
  endtask

  task automatic test_mask_clamp();
    int w;
    push_exp(32'h000FFFFF, 20, 1'b1);
    send(16'hFFFF, 4, 1'b0, w);
    send(16'hFFFF, 31, 1'b1, w);
    wait_empty();
  endtask

  task automatic test_backpressure();
    int w;
    out_ready_i = 1'b0;
    send(16'h1234, 16, 1'b0, w);
    send(16'hABCD, 16, 1'b0, w);
    in_valid_i = 1'b1; in_data_i = 16'h1111; in_len_i = 5'd16; in_last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'hABCD1234 || in_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%0b data=%h ready=%0b want 1 abcd1234 0",
                 i, out_valid_o, out_data_o, in_ready_o);
      end
    end
    @(posedge clk_i); #1;
    push_exp(32'hABCD1234, 32, 1'b0);
    push_exp(32'h22221111, 32, 1'b0);
    push_exp(32'h44443333, 32, 1'b1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'(i + 1);
      send(d, 16, (i == 3), w);
      checks++;
      if (w != 0) begin
        failures++;
        $display("FAIL bp_bubble field=%0d waits=%0d want 0", i, w);
      end
    end
    wait_empty();
  endtask

  task automatic test_empty_flush();
    int w;
    push_exp(32'h0, 0, 1'b1);
    send(16'h0000, 0, 1'b1, w);
    wait_empty();
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL empty_flush_after ready=%0b valid=%0b want 1 0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_random_packet();
    int w;
    model_buf = '0;
    model_fill = 0;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      int          len;
      d   = 16'($urandom);
      len = int'($urandom_range(0, 31));
      if (len > 20) len = 16;
      model_field(d, len, (i == 39));
      out_ready_i = ($urandom_range(0, 3) != 0);
      send(d, len, (i == 39), w);
    end
    wait_empty();
  endtask

  task automatic test_reset_mid_drain();
    int w;
    out_ready_i = 1'b0;
    send(16'hAAAA, 16, 1'b0, w);
    send(16'h5555, 8, 1'b1, w);
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1 || out_last_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_before_reset valid=%0b last=%0b want 1 1", out_valid_o, out_last_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, out_data_o, out_bits_o, out_last_o} !== {1'b0, 32'h0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset v=%0b d=%h b=%0d l=%0b want 0 0 0 0",
               out_valid_o, out_data_o, out_bits_o, out_last_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o} !== {1'b0, 32'h0, 6'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL post_reset v=%0b d=%h b=%0d l=%0b r=%0b want 0 0 0 0 1",
               out_valid_o, out_data_o, out_bits_o, out_last_o, in_ready_o);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    push_exp(32'h00000006, 3, 1'b1);
    send(16'h0002, 2, 1'b0, w);
    send(16'h0001, 1, 1'b1, w);
    wait_empty();
  endtask

  initial begin
    test_reset();
    test_exact_fill();
    test_straddle_flush();
    test_mask_clamp();
    test_backpressure();
    test_empty_flush();
    test_random_packet();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
